// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, drives the instruction ROM and registers the word into IF/ID.
// Latency: 1 cycle from rom_addr_o to id_inst_o; first valid word on the third edge after reset.
// Backpressure: stall_id freezes PC, IF/ID and counter; stall_if holds PC and injects bubbles.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_if,
    input  logic             stall_id,
    input  logic             branch_flag_i,
    input  logic [31:0]      branch_target_i,
    input  logic             flush_i,
    input  logic [31:0]      new_pc_i,
    output logic             rom_ce_o,
    output logic [31:0]      rom_addr_o,
    input  logic [31:0]      rom_inst_i,
    output logic [31:0]      id_pc_o,
    output logic [31:0]      id_inst_o,
    output logic             id_valid_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    localparam logic        CHIP_ENABLE  = 1'b1;
    localparam logic        CHIP_DISABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;

    // Both outputs come straight from flops, so no input reaches them combinationally.
    assign rom_addr_o = pc;
    assign rom_ce_o   = (state == RUN) ? CHIP_ENABLE : CHIP_DISABLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            id_pc_o     <= ZERO_WORD;
            id_inst_o   <= ZERO_WORD;
            id_valid_o  <= 1'b0;
            misalign_o  <= 1'b0;
            fetch_cnt_o <= '0;
        end else if (state == IDLE) begin
            state      <= RUN;
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            if (flush_i) begin
                pc         <= {new_pc_i[31:2], 2'b00};
                id_pc_o    <= ZERO_WORD;
                id_inst_o  <= ZERO_WORD;
                id_valid_o <= 1'b0;
                misalign_o <= |new_pc_i[1:0];
            end else if (stall_id) begin
                // decode busy: hold everything; a pending branch is re-presented later
            end else if (stall_if) begin
                id_pc_o    <= ZERO_WORD;
                id_inst_o  <= ZERO_WORD;
                id_valid_o <= 1'b0;
            end else begin
                id_pc_o     <= pc;
                id_inst_o   <= rom_inst_i;
                id_valid_o  <= 1'b1;
                fetch_cnt_o <= fetch_cnt_o + CNT_W'(1);
                // The word fetched this cycle is the delay slot; the target follows.
                if (branch_flag_i) begin
                    pc         <= {branch_target_i[31:2], 2'b00};
                    misalign_o <= |branch_target_i[1:0];
                end else begin
                    pc <= pc + 32'd4;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a combinational ROM model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_if, stall_id, branch_flag_i, flush_i;
    logic [31:0] branch_target_i, new_pc_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o, rom_inst_i;
    logic [31:0] id_pc_o, id_inst_o;
    logic        id_valid_o, misalign_o;
    logic [31:0] fetch_cnt_o;

    logic [31:0] mem [64];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign rom_inst_i = mem[rom_addr_o[7:2]];

    inst_fetch #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .flush_i(flush_i), .new_pc_i(new_pc_i),
        .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_inst_i(rom_inst_i),
        .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_valid_o(id_valid_o),
        .misalign_o(misalign_o), .fetch_cnt_o(fetch_cnt_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_if = 0; stall_id = 0; branch_flag_i = 0; flush_i = 0;
        branch_target_i = 32'h0; new_pc_i = 32'h0;
    endtask

    // Reset edge plus the IDLE->RUN edge; leaves pc=0 with ROM enabled.
    task automatic do_reset();
        rst = 1; step(); rst = 0; step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; step();
        n_tests++; if (rom_ce_o !== 1'b0) begin n_fail++; $display("FAIL rst_ce got %h exp 0", rom_ce_o); end
        n_tests++; if (rom_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", rom_addr_o); end
        n_tests++; if (id_valid_o !== 1'b0 || id_inst_o !== 32'h0 || id_pc_o !== 32'h0) begin
            n_fail++; $display("FAIL rst_ifid got v=%h i=%h p=%h exp 0/0/0", id_valid_o, id_inst_o, id_pc_o); end
        n_tests++; if (fetch_cnt_o !== 32'h0 || misalign_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_cnt got cnt=%h mis=%h exp 0/0", fetch_cnt_o, misalign_o); end
        rst = 0; step();
        n_tests++; if (rom_ce_o !== 1'b1 || id_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL idle_run got ce=%h v=%h exp 1/0", rom_ce_o, id_valid_o); end
        step();
        n_tests++; if (id_inst_o !== 32'h34011100 || id_pc_o !== 32'h0 || id_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL first_word got i=%h p=%h v=%h exp 34011100/0/1", id_inst_o, id_pc_o, id_valid_o); end
        step();
        n_tests++; if (id_inst_o !== 32'h34020020 || id_pc_o !== 32'h4) begin
            n_fail++; $display("FAIL second_word got i=%h p=%h exp 34020020/4", id_inst_o, id_pc_o); end
        step();
        n_tests++; if (id_inst_o !== 32'h3403ff00 || id_pc_o !== 32'h8 || fetch_cnt_o !== 32'd3) begin
            n_fail++; $display("FAIL third_word got i=%h p=%h cnt=%0d exp 3403ff00/8/3", id_inst_o, id_pc_o, fetch_cnt_o); end
    endtask

    task automatic test_branch();
        idle_inputs(); do_reset();
        step(); step();
        branch_flag_i = 1; branch_target_i = 32'h40; step();
        branch_flag_i = 0;
        n_tests++; if (id_pc_o !== 32'h8 || rom_addr_o !== 32'h40 || misalign_o !== 1'b0) begin
            n_fail++; $display("FAIL br_slot got p=%h a=%h m=%h exp 8/40/0", id_pc_o, rom_addr_o, misalign_o); end
        step();
        n_tests++; if (id_pc_o !== 32'h40 || id_inst_o !== 32'hA000_0010 || misalign_o !== 1'b0) begin
            n_fail++; $display("FAIL br_target got p=%h i=%h m=%h exp 40/a0000010/0", id_pc_o, id_inst_o, misalign_o); end
        n_tests++; if (fetch_cnt_o !== 32'd4) begin n_fail++; $display("FAIL br_cnt got %0d exp 4", fetch_cnt_o); end
    endtask

    task automatic test_stalls();
        idle_inputs(); do_reset();
        step(); step(); step();
        stall_if = 1;
        for (int k = 0; k < 2; k++) begin
            step();
            n_tests++; if (id_valid_o !== 1'b0 || id_inst_o !== 32'h0 || rom_addr_o !== 32'hC || fetch_cnt_o !== 32'd3) begin
                n_fail++; $display("FAIL stall_if%0d got v=%h i=%h a=%h cnt=%0d exp 0/0/c/3", k, id_valid_o, id_inst_o, rom_addr_o, fetch_cnt_o); end
        end
        stall_if = 0; step();
        n_tests++; if (id_pc_o !== 32'hC || id_inst_o !== 32'hA000_0003 || fetch_cnt_o !== 32'd4) begin
            n_fail++; $display("FAIL stall_if_rel got p=%h i=%h cnt=%0d exp c/a0000003/4", id_pc_o, id_inst_o, fetch_cnt_o); end
        stall_id = 1; branch_flag_i = 1; branch_target_i = 32'h80;
        for (int k = 0; k < 2; k++) begin
            stall_if = (k == 1);
            step();
            n_tests++; if (id_pc_o !== 32'hC || id_valid_o !== 1'b1 || fetch_cnt_o !== 32'd4 || rom_addr_o !== 32'h10) begin
                n_fail++; $display("FAIL stall_id%0d got p=%h v=%h cnt=%0d a=%h exp c/1/4/10", k, id_pc_o, id_valid_o, fetch_cnt_o, rom_addr_o); end
        end
        stall_id = 0; stall_if = 0; step();
        branch_flag_i = 0;
        n_tests++; if (id_pc_o !== 32'h10 || rom_addr_o !== 32'h80 || fetch_cnt_o !== 32'd5) begin
            n_fail++; $display("FAIL stall_id_rel got p=%h a=%h cnt=%0d exp 10/80/5", id_pc_o, rom_addr_o, fetch_cnt_o); end
    endtask

    task automatic test_flush();
        flush_i = 1; new_pc_i = 32'h23; stall_id = 1; branch_flag_i = 1; branch_target_i = 32'h40;
        step();
        flush_i = 0; stall_id = 0; branch_flag_i = 0;
        n_tests++; if (rom_addr_o !== 32'h20 || id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || misalign_o !== 1'b1 || fetch_cnt_o !== 32'd5) begin
            n_fail++; $display("FAIL flush got a=%h v=%h p=%h m=%h cnt=%0d exp 20/0/0/1/5", rom_addr_o, id_valid_o, id_pc_o, misalign_o, fetch_cnt_o); end
        step();
        n_tests++; if (misalign_o !== 1'b0 || id_pc_o !== 32'h20 || id_inst_o !== 32'hA000_0008) begin
            n_fail++; $display("FAIL flush_after got m=%h p=%h i=%h exp 0/20/a0000008", misalign_o, id_pc_o, id_inst_o); end
    endtask

    task automatic test_wrap();
        flush_i = 1; new_pc_i = 32'hFFFF_FFFC; step();
        flush_i = 0;
        n_tests++; if (rom_addr_o !== 32'hFFFF_FFFC || misalign_o !== 1'b0) begin
            n_fail++; $display("FAIL wrap_flush got a=%h m=%h exp fffffffc/0", rom_addr_o, misalign_o); end
        step();
        n_tests++; if (rom_addr_o !== 32'h0 || id_pc_o !== 32'hFFFF_FFFC || id_inst_o !== 32'hA000_003F) begin
            n_fail++; $display("FAIL wrap got a=%h p=%h i=%h exp 0/fffffffc/a000003f", rom_addr_o, id_pc_o, id_inst_o); end
        branch_flag_i = 1; branch_target_i = 32'h42; step();
        branch_flag_i = 0;
        n_tests++; if (misalign_o !== 1'b1 || rom_addr_o !== 32'h40) begin
            n_fail++; $display("FAIL br_misalign got m=%h a=%h exp 1/40", misalign_o, rom_addr_o); end
        step();
        n_tests++; if (misalign_o !== 1'b0 || rom_addr_o !== 32'h44) begin
            n_fail++; $display("FAIL br_misalign_clr got m=%h a=%h exp 0/44", misalign_o, rom_addr_o); end
    endtask

    task automatic test_reset_mid_stall();
        flush_i = 1; new_pc_i = 32'h40; step();
        flush_i = 0; stall_id = 1; step();
        n_tests++; if (rom_addr_o !== 32'h40) begin n_fail++; $display("FAIL pre_rst_pc got %h exp 40", rom_addr_o); end
        rst = 1; step();
        n_tests++; if (rom_ce_o !== 1'b0 || rom_addr_o !== 32'h0 || id_valid_o !== 1'b0 || id_pc_o !== 32'h0
                       || id_inst_o !== 32'h0 || fetch_cnt_o !== 32'h0 || misalign_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_stall got ce=%h a=%h v=%h p=%h i=%h cnt=%0d m=%h exp all 0",
                               rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, fetch_cnt_o, misalign_o); end
        rst = 0; stall_id = 0; step();
        n_tests++; if (rom_ce_o !== 1'b1 || id_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_stall_run got ce=%h v=%h exp 1/0", rom_ce_o, id_valid_o); end
        step();
        n_tests++; if (id_pc_o !== 32'h0 || id_inst_o !== 32'h34011100 || fetch_cnt_o !== 32'd1) begin
            n_fail++; $display("FAIL rst_stall_restart got p=%h i=%h cnt=%0d exp 0/34011100/1", id_pc_o, id_inst_o, fetch_cnt_o); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h34011100; mem[1] = 32'h34020020; mem[2] = 32'h3403ff00;
        rst = 1; idle_inputs();
        test_reset();
        test_branch();
        test_stalls();
        test_flush();
        test_wrap();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch front end of the five-stage core: owns the program counter, drives the chip-enable and address of the instruction ROM, captures the returned word and presents it to the decode stage through a registered IF/ID boundary. The ROM answers combinationally within the same cycle, so fetch latency is set entirely by this block. It handles pipeline stall, delayed-branch redirect and flush, and keeps a retired-fetch counter for the bench.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- CNT_W, 32, width of the fetch counter.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_if  in  1  hold the PC; do not deliver a new word.
- stall_id  in  1  decode stage busy; hold the IF/ID register.
- branch_flag_i  in  1  redirect request from decode (delayed branch).
- branch_target_i  in  32  redirect address.
- flush_i  in  1  exception/flush; highest priority.
- new_pc_i  in  32  flush target.
- rom_ce_o  out  1  ROM chip enable; `ChipEnable` when fetching.
- rom_addr_o  out  32  byte address to ROM (`InstAddrBus`), equals PC.
- rom_inst_i  in  32  word from ROM (`InstBus`), valid same cycle.
- id_pc_o  out  32  PC of word in IF/ID.
- id_inst_o  out  32  instruction in IF/ID.
- id_valid_o  out  1  IF/ID holds a real instruction.
- misalign_o  out  1  one-cycle pulse: redirect target had addr[1:0]≠0.
- fetch_cnt_o  out  CNT_W  words delivered to decode since reset.

## Operation

- States: IDLE (ROM disabled) and RUN (ROM enabled).
- Reset (rst=1 at edge): state←IDLE, pc←RESET_PC, rom_ce_o←`ChipDisable`, id_pc_o←0, id_inst_o←`ZeroWord`, id_valid_o←0, misalign_o←0, fetch_cnt_o←0. Reset overrides every other input and is honoured mid-stall or mid-redirect.
- IDLE: next edge with rst=0 → RUN, rom_ce_o←1, pc unchanged (RESET_PC). IF/ID stays invalid. No other input has effect in IDLE.
- RUN, per edge, priority order:
  1. flush_i=1: pc←{new_pc_i[31:2],2'b00}; id_inst_o←0, id_pc_o←0, id_valid_o←0; misalign_o←|new_pc_i[1:0]. Stalls ignored.
  2. stall_id=1: pc, IF/ID, counter all hold (stall_if value irrelevant).
  3. stall_if=1, stall_id=0: pc holds; bubble into IF/ID (id_valid_o←0, id_inst_o←0, id_pc_o←0).
  4. no stall: id_pc_o←pc, id_inst_o←rom_inst_i, id_valid_o←1, fetch_cnt_o←+1; pc←{branch_target_i[31:2],2'b00} if branch_flag_i else pc+4.
- branch_flag_i is ignored on any edge where case 1–3 applies; decode re-asserts it until it is accepted.
- Delayed branch: the word at pc when branch_flag_i is accepted (delay slot) is delivered normally; the following fetch is at the target.
- misalign_o high only for the cycle after an accepted misaligned redirect (case 1 or 4 with branch); otherwise 0.
- pc+4 wraps 32'hFFFF_FFFC→0. fetch_cnt_o wraps modulo 2^CNT_W.
- rom_addr_o = pc register directly; rom_ce_o = (state==RUN).

## Timing

- Fetch-to-decode latency: 1 cycle (word at rom_addr_o in cycle n appears on id_inst_o after edge n).
- Throughput: one word per cycle when unstalled.
- First valid id_inst_o: third edge counting the edge that samples rst=1 (reset edge, IDLE→RUN edge, first capture edge).
- Redirect penalty: zero beyond the delay slot; target word is on rom_addr_o the cycle after acceptance.
- All outputs registered; no combinational path from any input to any output.

## Test plan

- Reset/startup: ROM preloaded 0x34011100,0x34020020,0x3403ff00; release rst → rom_ce_o 0 then 1; id_inst_o sequence 0x34011100,0x34020020,0x3403ff00 with id_pc_o 0,4,8; fetch_cnt_o=3.
- Branch with delay slot: branch_flag_i=1, target 0x40 while pc=0x8 → id_pc_o 0x8 then 0x40; misalign_o stays 0.
- Stalls: stall_if=1 two cycles at pc=0xC → two bubbles (id_valid_o=0), pc holds 0xC; stall_id=1 → IF/ID and counter frozen, branch_flag_i ignored until released.
- Flush priority: flush_i=1, new_pc_i=0x23 with stall_id=1 and branch_flag_i=1 → pc=0x20, id_valid_o=0, misalign_o=1 for exactly one cycle.
- Wrap: flush to 0xFFFF_FFFC then run → next rom_addr_o 0x0000_0000.
- Reset mid-stall: rst=1 during stall_id=1 with pc=0x40 → all outputs return to reset values next edge, fetch restarts at RESET_PC.
